// File: rtl/sample_mem_pkg.sv
// Shared types and default sizes for the sample RAM arbiter.
// Optional build macro: WR_AUTO_ADDR_EN (used by sample_mem_arbiter).
package sample_mem_pkg;

    // Owner of the single RAM port in the current cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } grant_e;

    localparam int DEF_DW           = 16;
    localparam int DEF_AW           = 16;
    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int DEF_STARVE_LIMIT = 3;
    localparam int DEF_FRAME_LEN    = 256;

endpackage

// File: rtl/sample_skid_fifo.sv
// Small skid FIFO for writer samples. A push into a full FIFO is still
// accepted when a pop happens in the same cycle; otherwise it is dropped.
module sample_skid_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         full,
    output logic         empty,
    output logic         drop
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full      = (count_q == (PW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign drop      = push && !do_push;
    assign head_data = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of 2).
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset empties the queue regardless of stored contents.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is assigned with '<=' only; '=' here would create order-dependent races.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sample storage.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; entries are only visible through count_q, which is reset.
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/sample_mem_arbiter.sv
// Arbitrates the single-port sample RAM between the receiver writer (via a
// skid FIFO, priority) and the DSP reader (starvation guard), and counts
// accepted writes into frames.
// Optional build macro: WR_AUTO_ADDR_EN -- write address is generated as
// {frame_count[0], write offset} (ping-pong banks) instead of wr_addr.
// That mode needs FRAME_LEN a power of 2 with log2(FRAME_LEN)+1 <= AW.
module sample_mem_arbiter
    import sample_mem_pkg::*;
#(
    parameter int DW           = DEF_DW,
    parameter int AW           = DEF_AW,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int FRAME_LEN    = DEF_FRAME_LEN
) (
    input  logic          dsp_clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_gnt,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          frame_ready,
    output logic [15:0]   frame_count,
    output logic          overflow,
    input  logic          ovf_clr
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int OW = $clog2(FRAME_LEN);
    localparam logic [SW-1:0] STARVE_MAX  = SW'(STARVE_LIMIT);
    localparam logic [OW-1:0] OFFSET_LAST = OW'(FRAME_LEN - 1);

`ifdef WR_AUTO_ADDR_EN
    localparam int EW = DW;
`else
    localparam int EW = AW + DW;
`endif

    grant_e        grant;
    logic          force_rd;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          wr_drop;
    logic [EW-1:0] fifo_push_data;
    logic [EW-1:0] fifo_head;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_wdata;

    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic [OW-1:0] offset_q, offset_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic          frame_ready_q, frame_ready_d;
    logic          overflow_q, overflow_d;
    logic          rd_valid_q, rd_valid_d;

`ifdef WR_AUTO_ADDR_EN
    assign fifo_push_data = wr_data;
    assign head_addr      = AW'({frame_count_q[0], offset_q});
`else
    assign fifo_push_data = {wr_addr, wr_data};
    assign head_addr      = fifo_head[EW-1:DW];
`endif
    assign head_wdata = fifo_head[DW-1:0];

    sample_skid_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (dsp_clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (wr_drop)
    );

    assign force_rd = rd_req && (STARVE_LIMIT != 0) && (starve_cnt_q == STARVE_MAX);
    assign fifo_pop = (grant == GNT_WR);

    // Grant decision: forced reader slot, else queued writes, else reader.
    always_comb begin
        grant = GNT_NONE;
        if (force_rd) begin
            grant = GNT_RD;
        end else if (!fifo_empty) begin
            grant = GNT_WR;
        end else if (rd_req) begin
            grant = GNT_RD;
        end
    end

    // RAM port and read-grant drive; address/data are zero unless a write owns the port
    // (a read drives its own address).
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rd_gnt    = 1'b0;
        unique case (grant)
            GNT_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = head_addr;
                mem_wdata = head_wdata;
            end
            GNT_RD: begin
                mem_en   = 1'b1;
                mem_addr = rd_addr;
                rd_gnt   = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state for starvation counter, frame tracking, overflow flag and read-valid.
    always_comb begin
        starve_cnt_d  = starve_cnt_q;
        offset_d      = offset_q;
        frame_count_d = frame_count_q;
        frame_ready_d = 1'b0;
        overflow_d    = overflow_q;
        rd_valid_d    = rd_gnt;

        if (!rd_req || rd_gnt) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end

        if (grant == GNT_WR) begin
            if (offset_q == OFFSET_LAST) begin
                offset_d      = '0;
                frame_ready_d = 1'b1;
                frame_count_d = frame_count_q + 16'd1;
            end else begin
                offset_d = offset_q + OW'(1);
            end
        end

        // A drop in the same cycle as a clear keeps the flag set.
        if (wr_drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    // Arbiter state registers; reset also kills any in-flight read-valid.
    always_ff @(posedge dsp_clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q  <= '0;
            offset_q      <= '0;
            frame_count_q <= '0;
            frame_ready_q <= 1'b0;
            overflow_q    <= 1'b0;
            rd_valid_q    <= 1'b0;
        end else begin
            starve_cnt_q  <= starve_cnt_d;
            offset_q      <= offset_d;
            frame_count_q <= frame_count_d;
            frame_ready_q <= frame_ready_d;
            overflow_q    <= overflow_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    assign rd_valid    = rd_valid_q;
    assign rd_data     = mem_rdata;
    assign frame_ready = frame_ready_q;
    assign frame_count = frame_count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_sample_mem_arbiter.sv
// Directed, scoreboard-based bench for sample_mem_arbiter
// (FIFO_DEPTH=4, STARVE_LIMIT=3, FRAME_LEN=4). Honours WR_AUTO_ADDR_EN.
module tb_sample_mem_arbiter;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int FD = 4;
    localparam int SL = 3;
    localparam int FL = 4;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic          dsp_clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          frame_ready;
    logic [15:0]   frame_count;
    logic          overflow;
    logic          ovf_clr;

    int n_asrt = 0;
    int n_fail = 0;
    int w_seen = 0;
    wr_t wq[$];
    logic [15:0] rq[$];

    sample_mem_arbiter #(
        .DW(DW), .AW(AW), .FIFO_DEPTH(FD), .STARVE_LIMIT(SL), .FRAME_LEN(FL)
    ) dut (
        .dsp_clk     (dsp_clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_gnt      (rd_gnt),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .frame_ready (frame_ready),
        .frame_count (frame_count),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr)
    );

    always #5 dsp_clk = ~dsp_clk;

    // RAM model with 1-cycle read latency: address 16'hXY.. returns {4{addr[7:4]}}.
    always @(posedge dsp_clk) begin
        if (mem_en && !mem_we) mem_rdata <= {4{mem_addr[7:4]}};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_waddr(input logic [15:0] a, input int n);
`ifdef WR_AUTO_ADDR_EN
        return 16'(((n / FL) % 2) * FL + (n % FL));
`else
        return a;
`endif
    endfunction

    task automatic pop_write(input string tag);
        wr_t e;
        check({tag, "_sb_nonempty"}, 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
            e = wq.pop_front();
            check({tag, "_addr"}, 32'(mem_addr), 32'(exp_waddr(e.addr, w_seen)));
            check({tag, "_data"}, 32'(mem_wdata), 32'(e.data));
            w_seen++;
        end
    endtask

    task automatic pop_read(input string tag);
        logic [15:0] e;
        check({tag, "_rq_nonempty"}, 32'(rq.size() != 0), 32'd1);
        if (rq.size() != 0) begin
            e = rq.pop_front();
            check({tag, "_rd_data"}, 32'(rd_data), 32'(e));
        end
    endtask

    task automatic step();
        @(posedge dsp_clk);
        #1;
    endtask

    task automatic settle();
        @(negedge dsp_clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_rd_gnt"}, 32'(rd_gnt), 32'd0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_frame_ready"}, 32'(frame_ready), 32'd0);
        check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  fcnt;
        int  scnt;
        int  pulses;
        logic ovf_m, gnt_prev, is_rd, is_wr, drop, fr_exp, fr_next;

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req = 1'b0; rd_addr = '0; ovf_clr = 1'b0;

        // Reset state
        step(); step(); settle();
        check_idle("reset");
        step(); rst = 1'b0;

        // Single write with idle reader
        wr_en = 1'b1; wr_addr = 16'h0010; wr_data = 16'h1111;
        wq.push_back('{16'h0010, 16'h1111});
        step(); wr_en = 1'b0; settle();
        check("wr1_mem_en", 32'(mem_en), 32'd1);
        check("wr1_mem_we", 32'(mem_we), 32'd1);
        check("wr1_rd_gnt", 32'(rd_gnt), 32'd0);
        pop_write("wr1");
        step(); settle();
        check("wr1_drained_mem_en", 32'(mem_en), 32'd0);

        // Read latency
        step(); rd_req = 1'b1; rd_addr = 16'h0020; settle();
        check("rd1_gnt", 32'(rd_gnt), 32'd1);
        check("rd1_mem_we", 32'(mem_we), 32'd0);
        check("rd1_mem_addr", 32'(mem_addr), 32'h0020);
        rq.push_back(16'h2222);
        step(); rd_req = 1'b0; rd_addr = '0; settle();
        check("rd1_valid", 32'(rd_valid), 32'd1);
        pop_read("rd1");
        step(); settle();
        check("rd1_valid_drop", 32'(rd_valid), 32'd0);

        // Starvation guard and overflow: writer every cycle, reader continuous
        step(); rst = 1'b1; step(); rst = 1'b0;
        wq.delete(); rq.delete(); w_seen = 0;
        fcnt = 0; scnt = 0; ovf_m = 1'b0; gnt_prev = 1'b0;
        for (int i = 0; i < 24; i++) begin
            wr_en = 1'b1; wr_addr = 16'h0100 + 16'(i); wr_data = 16'hA000 + 16'(i);
            rd_req = 1'b1; rd_addr = 16'h0030; ovf_clr = (i == 20 || i == 22);
            settle();
            is_rd = (scnt == SL) || (fcnt == 0);
            is_wr = !is_rd;
            check($sformatf("starve_rd_gnt_%0d", i), 32'(rd_gnt), 32'(is_rd));
            check($sformatf("starve_mem_we_%0d", i), 32'(mem_we), 32'(is_wr));
            check($sformatf("starve_overflow_%0d", i), 32'(overflow), 32'(ovf_m));
            check($sformatf("starve_rd_valid_%0d", i), 32'(rd_valid), 32'(gnt_prev));
            if (gnt_prev) pop_read($sformatf("starve_rd_%0d", i));
            if (is_rd) rq.push_back(16'h3333);
            if (is_wr) pop_write($sformatf("starve_wr_%0d", i));
            drop = (fcnt == FD) && !is_wr;
            if (drop) ovf_m = 1'b1;
            else if (ovf_clr) ovf_m = 1'b0;
            if (!drop) wq.push_back('{wr_addr, wr_data});
            fcnt = fcnt - int'(is_wr) + int'(!drop);
            scnt = is_rd ? 0 : ((scnt == SL) ? SL : scnt + 1);
            gnt_prev = is_rd;
            step();
        end

        // Reset mid-stream with a full queue and a read just granted
        wr_en = 1'b0; ovf_clr = 1'b0; rd_req = 1'b1; rd_addr = 16'h0030;
        settle();
        check("midrst_pre_rd_gnt", 32'(rd_gnt), 32'd1);
        #1 rst = 1'b1; rd_req = 1'b0; rd_addr = '0;
        #1 check_idle("midrst");
        step(); settle();
        check("midrst_no_rd_valid", 32'(rd_valid), 32'd0);
        step(); rst = 1'b0; rd_req = 1'b1; rd_addr = 16'h0020;
        wq.delete(); rq.delete(); w_seen = 0;
        settle();
        check("postrst_rd_gnt", 32'(rd_gnt), 32'd1);
        check("postrst_mem_we", 32'(mem_we), 32'd0);
        check("postrst_mem_en", 32'(mem_en), 32'd1);
        rq.push_back(16'h2222);
        step(); rd_req = 1'b0; rd_addr = '0; settle();
        check("postrst_rd_valid", 32'(rd_valid), 32'd1);
        pop_read("postrst");

        // Frames: 8 accepted writes, one every other cycle
        step();
        fr_exp = 1'b0; pulses = 0;
        for (int i = 0; i < 18; i++) begin
            wr_en = (i % 2 == 0) && (i < 16);
            wr_addr = 16'h0040 + 16'(i); wr_data = 16'hF000 + 16'(i);
            if (wr_en) wq.push_back('{wr_addr, wr_data});
            settle();
            is_wr = (i % 2 == 1) && (i < 16);
            check($sformatf("frame_mem_we_%0d", i), 32'(mem_we), 32'(is_wr));
            check($sformatf("frame_ready_%0d", i), 32'(frame_ready), 32'(fr_exp));
            if (frame_ready) pulses++;
            fr_next = 1'b0;
            if (is_wr) begin
                pop_write($sformatf("frame_wr_%0d", i));
                fr_next = (w_seen % FL == 0);
            end
            fr_exp = fr_next;
            step();
        end
        wr_en = 1'b0;
        settle();
        check("frame_count_final", 32'(frame_count), 32'd2);
        check("frame_pulses", 32'(pulses), 32'd2);
        check("frame_sb_empty", 32'(wq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
